// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the hazard/stall control slice.
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam int MD_LATENCY_DEF = 8;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    function automatic logic reg_match(input logic en, input logic [REG_W-1:0] dest,
                                       input logic [REG_W-1:0] r);
        return en && (dest == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// MUL/DIV occupancy tracker: IDLE/BUSY FSM with countdown, done pulse and sticky overlap error.
module md_busy_tracker
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    output logic md_busy,
    output logic md_done,
    output logic md_overlap_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        case (state)
            MD_IDLE: begin
                if (md_start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // A new start while busy restarts the countdown rather than queueing.
                if (md_start) begin
                    err_nxt = 1'b1;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = MD_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy        = (state == MD_BUSY);
        md_done        = (state == MD_BUSY) && (cnt == CNT_ONE);
        md_overlap_err = err;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use, branch-in-ID and MUL/DIV stalls plus IF/ID flush.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_addr_id,
    input  logic [REG_W-1:0] rt_addr_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic             branch_id,
    input  logic             branch_taken_id,
    input  logic             md_use_id,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    input  logic [REG_W-1:0] dest_addr_ex,
    input  logic             md_start_ex,
    input  logic             memread_mem,
    input  logic [REG_W-1:0] dest_addr_mem,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_overlap_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, br_hz, md_hz, stall, flush;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk            (clk),
        .rst            (rst),
        .md_start       (md_start_ex),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .md_overlap_err (md_overlap_err)
    );

    always_comb begin
        ex_rs  = reg_match(regwrite_ex, dest_addr_ex, rs_addr_id);
        ex_rt  = reg_match(regwrite_ex, dest_addr_ex, rt_addr_id);
        mem_rs = reg_match(memread_mem, dest_addr_mem, rs_addr_id);
        mem_rt = reg_match(memread_mem, dest_addr_mem, rt_addr_id);

        load_use = memread_ex && ((rs_used_id && ex_rs) || (rt_used_id && ex_rt));
        // Branches compare in ID, so any EX producer or a load still in MEM is too late to forward.
        br_hz    = branch_id && ((rs_used_id && (ex_rs || mem_rs)) ||
                                 (rt_used_id && (ex_rt || mem_rt)));
        // The waiter may issue on the done cycle; it reaches EX just as the unit frees.
        md_hz    = md_use_id && md_busy && !md_done;
        stall    = load_use || br_hz || md_hz;
        // A taken branch under stall read stale operands; it is re-resolved next cycle.
        flush    = branch_taken_id && !stall;

        pc_write   = !rst && !stall;
        ifid_write = !rst && !stall;
        ifid_flush = !rst && flush;
        idex_stall = rst || stall;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall) stall_cycles <= stall_cycles + 32'd1;
            if (flush) flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MD_LATENCY=8); perf checks under HAZARD_PERF_EN.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_addr_id, rt_addr_id, dest_addr_ex, dest_addr_mem;
    logic       rs_used_id, rt_used_id, branch_id, branch_taken_id, md_use_id;
    logic       memread_ex, regwrite_ex, md_start_ex, memread_mem;
    logic       pc_write, ifid_write, ifid_flush, idex_stall;
    logic       md_busy, md_done, md_overlap_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(8), .CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_addr_id      (rs_addr_id),
        .rt_addr_id      (rt_addr_id),
        .rs_used_id      (rs_used_id),
        .rt_used_id      (rt_used_id),
        .branch_id       (branch_id),
        .branch_taken_id (branch_taken_id),
        .md_use_id       (md_use_id),
        .memread_ex      (memread_ex),
        .regwrite_ex     (regwrite_ex),
        .dest_addr_ex    (dest_addr_ex),
        .md_start_ex     (md_start_ex),
        .memread_mem     (memread_mem),
        .dest_addr_mem   (dest_addr_mem),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .md_overlap_err  (md_overlap_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                           input logic fl, input logic st);
        check({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
        check({tag, ".ifid_write"}, 32'(ifid_write), 32'(ifw));
        check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
        check({tag, ".idex_stall"}, 32'(idex_stall), 32'(st));
    endtask

    task automatic idle_in();
        rs_addr_id = 5'd0; rt_addr_id = 5'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
        branch_id = 1'b0; branch_taken_id = 1'b0; md_use_id = 1'b0;
        memread_ex = 1'b0; regwrite_ex = 1'b0; dest_addr_ex = 5'd0; md_start_ex = 1'b0;
        memread_mem = 1'b0; dest_addr_mem = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        branch_taken_id = 1'b1;
        #3;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset.md_busy", 32'(md_busy), 32'd0);
        check("reset.md_done", 32'(md_done), 32'd0);
        check("reset.md_overlap_err", 32'(md_overlap_err), 32'd0);
        step(); step();
        rst = 1'b0;
        idle_in();
        #1 chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on rs: one stall, then released as the load moves to MEM.
        step();
        memread_ex = 1'b1; regwrite_ex = 1'b1; dest_addr_ex = 5'd5;
        rs_addr_id = 5'd5; rs_used_id = 1'b1;
        #1 chk_ctl("lu_stall", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        memread_ex = 1'b0; regwrite_ex = 1'b0; dest_addr_ex = 5'd0;
        memread_mem = 1'b1; dest_addr_mem = 5'd5;
        #1 chk_ctl("lu_release", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load to $0 never stalls.
        step(); idle_in();
        memread_ex = 1'b1; regwrite_ex = 1'b1; dest_addr_ex = 5'd0; rs_used_id = 1'b1;
        #1 chk_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on rt, then the same match with rt unused.
        step(); idle_in();
        memread_ex = 1'b1; regwrite_ex = 1'b1; dest_addr_ex = 5'd9;
        rt_addr_id = 5'd9; rt_used_id = 1'b1;
        #1 chk_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
        rt_used_id = 1'b0;
        #1 chk_ctl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);

        // ALU producer in EX does not stall a non-branch consumer.
        step(); idle_in();
        regwrite_ex = 1'b1; dest_addr_ex = 5'd3; rs_addr_id = 5'd3; rs_used_id = 1'b1;
        #1 chk_ctl("alu_nobranch", 1'b1, 1'b1, 1'b0, 1'b0);

        // Branch after load: two stalls, then the taken branch flushes once.
        step(); idle_in();
        memread_ex = 1'b1; regwrite_ex = 1'b1; dest_addr_ex = 5'd7;
        rs_addr_id = 5'd7; rs_used_id = 1'b1; branch_id = 1'b1; branch_taken_id = 1'b1;
        #1 chk_ctl("brld_c1", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        memread_ex = 1'b0; regwrite_ex = 1'b0; dest_addr_ex = 5'd0;
        memread_mem = 1'b1; dest_addr_mem = 5'd7;
        #1 chk_ctl("brld_c2", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        memread_mem = 1'b0; dest_addr_mem = 5'd0;
        #1 chk_ctl("brld_c3", 1'b1, 1'b1, 1'b1, 1'b0);
        step(); idle_in();
        #1 chk_ctl("brld_c4", 1'b1, 1'b1, 1'b0, 1'b0);

        // Branch after ALU op: one stall with flush held off, then flush.
        step(); idle_in();
        regwrite_ex = 1'b1; dest_addr_ex = 5'd3;
        rt_addr_id = 5'd3; rt_used_id = 1'b1; branch_id = 1'b1; branch_taken_id = 1'b1;
        #1 chk_ctl("bralu_c1", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        regwrite_ex = 1'b0; dest_addr_ex = 5'd0; dest_addr_mem = 5'd3;
        #1 chk_ctl("bralu_c2", 1'b1, 1'b1, 1'b1, 1'b0);

        // MUL/DIV: 7 busy cycles, done on the last, waiter released on done.
        step(); idle_in();
        md_start_ex = 1'b1;
        #1 check("md_start.busy", 32'(md_busy), 32'd0);
        step();
        md_start_ex = 1'b0; md_use_id = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("md_busy[%0d]", i), 32'(md_busy), 32'd1);
            check($sformatf("md_done[%0d]", i), 32'(md_done), 32'(i == 6));
            check($sformatf("md_stall[%0d]", i), 32'(idex_stall), 32'(i != 6));
            check($sformatf("md_pcw[%0d]", i), 32'(pc_write), 32'(i == 6));
            step();
        end
        md_use_id = 1'b0;
        #1 check("md_after.busy", 32'(md_busy), 32'd0);
        check("md_after.err", 32'(md_overlap_err), 32'd0);

        // Overlapping start at count 5: error set, busy runs 7 more cycles.
        step(); md_start_ex = 1'b1;
        step(); md_start_ex = 1'b0;
        step();
        step();
        md_start_ex = 1'b1;
        #1 check("ovl_pre.err", 32'(md_overlap_err), 32'd0);
        step();
        md_start_ex = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("ovl_busy[%0d]", i), 32'(md_busy), 32'd1);
            check($sformatf("ovl_done[%0d]", i), 32'(md_done), 32'(i == 6));
            check($sformatf("ovl_err[%0d]", i), 32'(md_overlap_err), 32'd1);
            step();
        end
        #1 check("ovl_after.busy", 32'(md_busy), 32'd0);
        check("ovl_after.err_sticky", 32'(md_overlap_err), 32'd1);

        // Asynchronous reset mid-busy abandons the operation.
        step(); md_start_ex = 1'b1;
        step(); md_start_ex = 1'b0;
        step();
        #1 check("rstmid.pre_busy", 32'(md_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid.busy", 32'(md_busy), 32'd0);
        check("rstmid.err", 32'(md_overlap_err), 32'd0);
        chk_ctl("rstmid", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("postrst_done[%0d]", i), 32'(md_done), 32'd0);
            check($sformatf("postrst_busy[%0d]", i), 32'(md_busy), 32'd0);
            step();
        end
`ifdef HAZARD_PERF_EN
        check("perf.stall_after_rst", stall_cycles, 32'd0);
        check("perf.flush_after_rst", flush_count, 32'd0);
        memread_ex = 1'b1; regwrite_ex = 1'b1; dest_addr_ex = 5'd4;
        rs_addr_id = 5'd4; rs_used_id = 1'b1;
        step(); idle_in();
        branch_taken_id = 1'b1;
        #1 check("perf.stall_one", stall_cycles, 32'd1);
        step(); idle_in();
        #1 check("perf.flush_one", flush_count, 32'd1);
        check("perf.stall_hold", stall_cycles, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller that produces the stall/bubble signal consumed by the ID/EX pipeline register, plus PC and IF/ID hold and flush controls.
- Detects the following and holds IF/ID while inserting bubbles into ID/EX:
  - load-use hazards
  - branch-in-ID operand hazards
  - multi-cycle MUL/DIV occupancy
- Sits beside the ID stage. Inputs come from the ID, EX and MEM stages; outputs go to the PC, IF/ID and ID/EX registers.

Parameters:
- MD_LATENCY, 8: EX-stage cycles a MUL/DIV occupies the HI/LO unit (legal range 2..32).
- CNT_W, 5: width of the MUL/DIV countdown counter; must satisfy 2^CNT_W >= MD_LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rs_addr_id  in  5  rs field of the instruction in ID
- rt_addr_id  in  5  rt field of the instruction in ID
- rs_used_id  in  1  the ID instruction reads rs
- rt_used_id  in  1  the ID instruction reads rt
- branch_id  in  1  the ID instruction is a branch or jr that compares/reads registers in ID
- branch_taken_id  in  1  branch resolved taken in ID
- md_use_id  in  1  the ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- memread_ex  in  1  the EX instruction is a load
- regwrite_ex  in  1  the EX instruction writes the register file
- dest_addr_ex  in  5  destination register of the EX instruction (after RegDst mux)
- md_start_ex  in  1  a mult/div is in EX this cycle
- memread_mem  in  1  the MEM instruction is a load
- dest_addr_mem  in  5  destination register of the MEM instruction
- pc_write  out  1  1 = PC may update
- ifid_write  out  1  1 = IF/ID may load
- ifid_flush  out  1  1 = IF/ID loads a NOP
- idex_stall  out  1  1 = ID/EX clears its control fields (bubble)
- md_busy  out  1  MUL/DIV unit occupied
- md_done  out  1  one-cycle pulse on the final busy cycle
- md_overlap_err  out  1  sticky flag: md_start_ex seen while busy

Behaviour:
- Reset:
  - While rst is high: pc_write=0, ifid_write=0, ifid_flush=0, idex_stall=1, md_busy=0, md_done=0, md_overlap_err=0.
  - State goes to IDLE and the counter to 0.
  - Reset mid-MUL/DIV abandons the operation; no md_done pulse is produced.
- Register 0 never causes a hazard: a match against address 0 is ignored.
- match_ex(r) = regwrite_ex & dest_addr_ex==r & r!=0.
- match_mem(r) = memread_mem & dest_addr_mem==r & r!=0.
- Hazard conditions, evaluated combinationally each cycle:
  - load_use = memread_ex & ((rs_used_id & match_ex(rs)) | (rt_used_id & match_ex(rt))).
  - br_hz = branch_id & ((rs_used_id & (match_ex(rs) | match_mem(rs))) | (rt_used_id & (match_ex(rt) | match_mem(rt)))).
    - Branch after ALU op: 1 stall.
    - Branch after load: 2 stalls (EX then MEM).
  - md_hz = md_use_id & md_busy & !md_done.
- stall = load_use | br_hz | md_hz. When stall=1:
  - pc_write=0, ifid_write=0, idex_stall=1.
  - Otherwise pc_write=1, ifid_write=1, idex_stall=0.
- ifid_flush = branch_taken_id & !stall. A taken branch under stall is ignored, because its operands are stale; it is re-evaluated on the next cycle.
- MUL/DIV FSM:
  - States: IDLE, BUSY.
  - IDLE: on md_start_ex, go to BUSY and load cnt = MD_LATENCY-1.
  - BUSY: cnt decrements each cycle.
    - md_done = (cnt==1) combinational.
    - When cnt==1, the next state is IDLE.
  - md_busy = (state==BUSY).
  - The instruction waiting on md_hz issues in the cycle md_done=1, so it enters EX the cycle after busy ends.
  - md_start_ex while in BUSY: set md_overlap_err (sticky until reset) and reload cnt = MD_LATENCY-1.
- Latency: all stall outputs are combinational from the inputs and registered state; there are zero cycles of added delay.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_cycles (32-bit): increments on every cycle with stall=1.
  - flush_count (32-bit): increments on every cycle with ifid_flush=1.
  - Both are cleared by rst and wrap at 2^32 to 0.
- When undefined, these ports and their counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg):
  - REG_W=5, REG_ZERO=5'd0
  - md_state_t enum {MD_IDLE, MD_BUSY}
  - MD_LATENCY_DEF
- Sub-module md_busy_tracker: the FSM, counter, md_done and md_overlap_err. The parent holds the hazard comparators and output muxing.

Test Plan:
- Load-use: lw to $5 in EX (memread_ex=1, dest_addr_ex=5), ID reads rs=5 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_stall=1, then all released.
- Register 0: lw to $0 in EX, ID reads rs=0 -> no stall.
- Branch after load: lw $7, then beq reading $7 -> stall for 2 consecutive cycles (EX match, then MEM match). Branch taken on cycle 3 -> ifid_flush=1 for exactly that cycle.
- Branch after ALU op: add $3, then bne reading $3 with branch_taken_id=1 -> ifid_flush=0 during the 1 stall cycle, then 1 the next cycle.
- MUL/DIV: md_start_ex pulse with MD_LATENCY=8, then mflo in ID -> md_busy high for 7 cycles, md_done on the 7th, stall released in that same cycle. Second md_start_ex mid-busy -> md_overlap_err=1 and busy extended by 7 cycles.
- Reset: assert rst during BUSY -> md_busy=0 and idex_stall=1 asynchronously. After deassertion, no md_done pulse; with HAZARD_PERF_EN, stall_cycles=0.
